dram_loader: RTL and testbench

//  Host-side load stage upstream of the SIMD top. Accepts a 32-bit word stream and packs
//  PE_ELEMENTS words into one vector line. Writes NUM_LINES lines into operand RAM A, then
//  NUM_LINES lines into RAM B, through those RAMs' write ports.

---
 rtl/simd_pkg.sv | 21 ++
 rtl/lane_packer.sv | 60 ++++++
 rtl/dram_loader.sv | 120 ++++++++++++
 tb/tb_dram_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD load path: lane/vector geometry and loader FSM states.
// No logic; type and constant definitions only.
// No flow control here; consumers define their own handshakes.
package simd_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_PE_ELEMENTS = 4;

  // One vector line, lane 0 in the least-significant slot.
  typedef logic [DEF_PE_ELEMENTS-1:0][DEF_DATA_WIDTH-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    FLUSH,
    RUN,
    DONE
  } loader_state_e;

endpackage

// File: rtl/lane_packer.sv
// Packs consecutive accepted words into a PE_ELEMENTS-wide vector line.
// Latency: line_valid pulses 1 cycle after the word filling the last lane is accepted.
// No backpressure: every accept is absorbed; the caller gates accept.
module lane_packer
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PE_ELEMENTS = DEF_PE_ELEMENTS
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [DATA_WIDTH-1:0]                  word,
  input  logic                                   accept,
  output logic                                   last_word,
  output logic                                   line_valid,
  output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] line
);

  localparam int LW = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(PE_ELEMENTS - 1);

  logic [LW-1:0]                          lane_cnt_q, lane_cnt_d;
  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic                                   line_valid_q, line_valid_d;

  // Word lands in the current lane; the cycle after the last lane fills, the
  // register holds the complete line, so it is presented straight from lanes_q.
  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    lanes_d      = lanes_q;
    line_valid_d = 1'b0;
    last_word    = accept && (lane_cnt_q == LAST_LANE);
    if (accept) begin
      lanes_d[lane_cnt_q] = word;
      if (lane_cnt_q == LAST_LANE) begin
        lane_cnt_d   = '0;
        line_valid_d = 1'b1;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end
  end

  // Pack state; reset discards any partially filled line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_cnt_q   <= '0;
      lanes_q      <= '0;
      line_valid_q <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      lanes_q      <= lanes_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign line_valid = line_valid_q;
  assign line       = lanes_q;

endmodule

// File: rtl/dram_loader.sv
// Streams words into operand RAM A then RAM B as packed lines, then runs the processor until stop.
// Latency: 1 cycle from last-lane accept to RAM write; run_valid 2 cycles after the final accept.
// s_ready is high only while loading; stream is never consumed in other states.
module dram_loader
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PE_ELEMENTS = DEF_PE_ELEMENTS,
  parameter int DRAM_DEPTH  = 256,
  parameter int NUM_LINES   = 256
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             start,
  input  logic [DATA_WIDTH-1:0]                            s_data,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  output logic                                             a_wr_en,
  output logic [$clog2(DRAM_DEPTH)-1:0]                    a_wr_addr,
  output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]           a_wr_data,
  output logic                                             b_wr_en,
  output logic [$clog2(DRAM_DEPTH)-1:0]                    b_wr_addr,
  output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0]           b_wr_data,
  output logic                                             run_valid,
  input  logic                                             stop,
  output logic                                             busy,
  output logic                                             done
);

  localparam int AW = $clog2(DRAM_DEPTH);
  localparam logic [AW-1:0] LAST_LINE = AW'(NUM_LINES - 1);

  loader_state_e state_q, state_d;
  logic [AW-1:0] line_cnt_q, line_cnt_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_b_q, wr_b_d;

  logic                                   accept;
  logic                                   last_word;
  logic                                   line_valid;
  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] line;

  assign s_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept  = s_valid && s_ready;

  lane_packer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PE_ELEMENTS (PE_ELEMENTS)
  ) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .word       (s_data),
    .accept     (accept),
    .last_word  (last_word),
    .line_valid (line_valid),
    .line       (line)
  );

  // Next state. The target RAM and address are captured at the last-lane accept,
  // so the line counter can advance (or wrap into LOAD_B) the same cycle while the
  // pending write still carries the old address and operand.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_b_d     = wr_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_A;
          line_cnt_d = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (last_word) begin
          wr_addr_d = line_cnt_q;
          wr_b_d    = (state_q == LOAD_B);
          if (line_cnt_q == LAST_LINE) begin
            line_cnt_d = '0;
            state_d    = (state_q == LOAD_A) ? LOAD_B : FLUSH;
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      FLUSH:   state_d = RUN;
      RUN:     if (stop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, line counter and pending-write descriptor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      line_cnt_q <= '0;
      wr_addr_q  <= '0;
      wr_b_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_b_q     <= wr_b_d;
    end
  end

  // Write demux: one packer feeds both RAMs, steered by the captured operand.
  assign a_wr_en   = line_valid && !wr_b_q;
  assign b_wr_en   = line_valid && wr_b_q;
  assign a_wr_addr = wr_addr_q;
  assign b_wr_addr = wr_addr_q;
  assign a_wr_data = line;
  assign b_wr_data = line;

  assign run_valid = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dram_loader.sv
// Bench for dram_loader: a small (2-line) and a full-depth (256-line) instance,
// expected writes queued at stimulus time and popped by a write-port monitor.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_dram_loader;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, start, stop, s_valid, sel;
  logic [31:0] s_data;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_b;
    logic [7:0] addr;
    vec_t       data;
  } wr_t;

  wr_t exp_q[2][$];

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance (sel=0) and full-depth instance (sel=1)
  logic       s_ready_s, a_wr_en_s, b_wr_en_s, run_valid_s, busy_s, done_s;
  logic [7:0] a_wr_addr_s, b_wr_addr_s;
  vec_t       a_wr_data_s, b_wr_data_s;
  logic       s_ready_l, a_wr_en_l, b_wr_en_l, run_valid_l, busy_l, done_l;
  logic [7:0] a_wr_addr_l, b_wr_addr_l;
  vec_t       a_wr_data_l, b_wr_data_l;

  dram_loader #(.DATA_WIDTH(32), .PE_ELEMENTS(4), .DRAM_DEPTH(256), .NUM_LINES(2)) dut_s (
    .clk(clk), .rstn(rstn), .start(start && !sel), .s_data(s_data),
    .s_valid(s_valid && !sel), .s_ready(s_ready_s),
    .a_wr_en(a_wr_en_s), .a_wr_addr(a_wr_addr_s), .a_wr_data(a_wr_data_s),
    .b_wr_en(b_wr_en_s), .b_wr_addr(b_wr_addr_s), .b_wr_data(b_wr_data_s),
    .run_valid(run_valid_s), .stop(stop && !sel), .busy(busy_s), .done(done_s)
  );

  dram_loader #(.DATA_WIDTH(32), .PE_ELEMENTS(4), .DRAM_DEPTH(256), .NUM_LINES(256)) dut_l (
    .clk(clk), .rstn(rstn), .start(start && sel), .s_data(s_data),
    .s_valid(s_valid && sel), .s_ready(s_ready_l),
    .a_wr_en(a_wr_en_l), .a_wr_addr(a_wr_addr_l), .a_wr_data(a_wr_data_l),
    .b_wr_en(b_wr_en_l), .b_wr_addr(b_wr_addr_l), .b_wr_data(b_wr_data_l),
    .run_valid(run_valid_l), .stop(stop && sel), .busy(busy_l), .done(done_l)
  );

  wire ready = sel ? s_ready_l   : s_ready_s;
  wire rv    = sel ? run_valid_l : run_valid_s;
  wire bsy   = sel ? busy_l      : busy_s;
  wire dn    = sel ? done_l      : done_s;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_wr(input int d, input logic a_en, input logic b_en,
                          input logic [7:0] a_addr, input logic [7:0] b_addr,
                          input vec_t a_dat, input vec_t b_dat);
    wr_t e;
    chk("wr_strobe_overlap", {a_en, b_en}, a_en ? 2'b10 : 2'b01);
    if (exp_q[d].size() == 0) begin
      chk("unexpected_wr", 1'b1, 1'b0);
    end else begin
      e = exp_q[d].pop_front();
      chk("wr_operand", b_en, e.is_b);
      chk("wr_addr", b_en ? b_addr : a_addr, e.addr);
      chk("wr_data", b_en ? b_dat : a_dat, e.data);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write of its instance.
  always @(negedge clk) begin
    if (a_wr_en_s || b_wr_en_s)
      check_wr(0, a_wr_en_s, b_wr_en_s, a_wr_addr_s, b_wr_addr_s, a_wr_data_s, b_wr_data_s);
    if (a_wr_en_l || b_wr_en_l)
      check_wr(1, a_wr_en_l, b_wr_en_l, a_wr_addr_l, b_wr_addr_l, a_wr_data_l, b_wr_data_l);
  end

  task automatic push_lines(input int nl, input logic [31:0] base, input int first, input int count);
    wr_t e;
    for (int l = first; l < first + count; l++) begin
      e.is_b = (l >= nl);
      e.addr = 8'(l % nl);
      for (int i = 0; i < 4; i++) e.data[i] = base + 32'(4 * l + i);
      exp_q[sel ? 1 : 0].push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic pstop, input logic pstart);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_data = w; stop = pstop; start = pstart;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (t == 50) chk("s_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic run_load(input int nl, input logic [31:0] base, input bit gaps,
                          input int stop_at, input int start_at);
    push_lines(nl, base, 0, 2 * nl);
    pulse_start();
    for (int k = 0; k < 8 * nl; k++)
      send_word(base + 32'(k), gaps ? int'($urandom_range(2, 4)) : 0, k == stop_at, k == start_at);
  endtask

  // Called right after the final accept: FLUSH then RUN, hold, stop, DONE, IDLE.
  task automatic finish_run(input int hold);
    @(negedge clk);
    chk("flush_run_valid", rv, 1'b0);
    chk("flush_busy", bsy, 1'b1);
    @(negedge clk);
    chk("run_valid_rise", rv, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("run_valid_hold", rv, 1'b1);
    end
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("done_pulse", {dn, rv, bsy}, 3'b101);
    @(negedge clk);
    chk("after_done", {dn, rv, bsy}, 3'b000);
    chk("scoreboard_drained", 32'(exp_q[sel ? 1 : 0].size()), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0;
    #12;
    chk("reset_outputs_s", {s_ready_s, a_wr_en_s, b_wr_en_s, run_valid_s, busy_s, done_s,
                            a_wr_addr_s, b_wr_addr_s, a_wr_data_s[0], b_wr_data_s[0]}, '0);
    chk("reset_outputs_l", {s_ready_l, a_wr_en_l, b_wr_en_l, run_valid_l, busy_l, done_l,
                            a_wr_addr_l, b_wr_addr_l, a_wr_data_l[0], b_wr_data_l[0]}, '0);
    @(posedge clk); #1 rstn = 1'b1;

    // 1: back-to-back words 1..16, two lines per operand
    run_load(2, 32'd1, 1'b0, -1, -1);
    finish_run(0);

    // 2: sparse stream, same contents
    run_load(2, 32'd1, 1'b1, -1, -1);
    finish_run(0);

    // 3: hold RUN for 10 cycles before stop
    run_load(2, 32'd1, 1'b0, -1, -1);
    finish_run(10);

    // 4: reset after 6 words of A; only the complete first line may be written
    push_lines(2, 32'd1, 0, 1);
    pulse_start();
    for (int k = 0; k < 6; k++) send_word(32'd1 + 32'(k), 0, 1'b0, 1'b0);
    @(posedge clk); #1 rstn = 1'b0;
    #1 chk("midreset_outputs", {s_ready_s, a_wr_en_s, b_wr_en_s, run_valid_s, busy_s, done_s}, '0);
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    chk("midreset_drained", 32'(exp_q[0].size()), 32'd0);
    run_load(2, 32'd101, 1'b0, -1, -1);
    finish_run(0);

    // 5: stop during LOAD_A (word 2) and start during LOAD_B (word 10) are ignored
    run_load(2, 32'd1, 1'b0, 2, 10);
    finish_run(2);

    // 6: full depth, incrementing data from 0
    sel = 1'b1;
    run_load(256, 32'd0, 1'b0, -1, -1);
    finish_run(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
